// File: rtl/spill_tracker.sv
// rtl/spill_tracker.sv - LIVE-gate spill tracker: debounced spill start, spill numbering, in-spill trigger count, per-spill summary
module spill_tracker #(
  parameter int SPILL_W  = 10,
  parameter int EVT_W    = 16,
  parameter int MIN_LIVE = 4,
  parameter int SATURATE = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               live,
  input  logic               trig,
  input  logic               clr_spillno,
  output logic [SPILL_W-1:0] spillno,
  output logic [EVT_W-1:0]   evtno,
  output logic               in_spill,
  output logic               spill_start,
  output logic               spill_done,
  output logic [EVT_W-1:0]   last_evtcnt,
  output logic               last_evt_ovf,
  output logic               spill_ovf
);

  typedef enum logic [1:0] {IDLE, ARM, IN_SPILL} state_t;

  localparam logic [8:0] MIN_LIVE_C = 9'(MIN_LIVE);

  state_t               state_q, state_d;
  logic [7:0]           hicnt_q, hicnt_d;
  logic [8:0]           hicnt_inc;
  logic                 do_start, do_done, do_count;
  logic                 evt_ovf;
  logic [SPILL_W-1:0]   spill_base, spillno_d;
  logic                 spill_ovf_base, spill_ovf_d;
  logic [EVT_W-1:0]     evtno_d;
  logic                 evt_ovf_d;

  assign hicnt_inc = {1'b0, hicnt_q} + 9'd1;
  assign in_spill  = (state_q == IN_SPILL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hicnt_q <= '0;
    end else begin
      state_q <= state_d;
      hicnt_q <= hicnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hicnt_d  = hicnt_q;
    do_start = 1'b0;
    do_done  = 1'b0;
    do_count = 1'b0;
    case (state_q)
      IDLE: begin
        if (live) begin
          if (MIN_LIVE_C <= 9'd1) begin
            state_d  = IN_SPILL;
            hicnt_d  = '0;
            do_start = 1'b1;
          end else begin
            state_d = ARM;
            hicnt_d = 8'd1;
          end
        end
      end
      ARM: begin
        if (!live) begin
          // glitch shorter than MIN_LIVE: drop it silently
          state_d = IDLE;
          hicnt_d = '0;
        end else if (hicnt_inc >= MIN_LIVE_C) begin
          state_d  = IN_SPILL;
          hicnt_d  = '0;
          do_start = 1'b1;
        end else begin
          hicnt_d = hicnt_inc[7:0];
        end
      end
      IN_SPILL: begin
        if (!live) begin
          state_d = IDLE;
          do_done = 1'b1;
        end else if (trig) begin
          do_count = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        hicnt_d = '0;
      end
    endcase
  end

  // clear is applied before a coincident start increment
  always_comb begin
    spill_base     = clr_spillno ? '0 : spillno;
    spill_ovf_base = clr_spillno ? 1'b0 : spill_ovf;
    spillno_d      = spill_base;
    spill_ovf_d    = spill_ovf_base;
    if (do_start) begin
      if (&spill_base) begin
        spill_ovf_d = 1'b1;
        spillno_d   = (SATURATE != 0) ? spill_base : '0;
      end else begin
        spillno_d = spill_base + SPILL_W'(1);
      end
    end
  end

  always_comb begin
    evtno_d   = evtno;
    evt_ovf_d = evt_ovf;
    if (do_start) begin
      evtno_d   = '0;
      evt_ovf_d = 1'b0;
    end else if (do_count) begin
      if (&evtno) begin
        evt_ovf_d = 1'b1;
        evtno_d   = (SATURATE != 0) ? evtno : '0;
      end else begin
        evtno_d = evtno + EVT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spillno      <= '0;
      spill_ovf    <= 1'b0;
      evtno        <= '0;
      evt_ovf      <= 1'b0;
      spill_start  <= 1'b0;
      spill_done   <= 1'b0;
      last_evtcnt  <= '0;
      last_evt_ovf <= 1'b0;
    end else begin
      spillno     <= spillno_d;
      spill_ovf   <= spill_ovf_d;
      evtno       <= evtno_d;
      evt_ovf     <= evt_ovf_d;
      spill_start <= do_start;
      spill_done  <= do_done;
      if (do_done) begin
        last_evtcnt  <= evtno;
        last_evt_ovf <= evt_ovf;
      end
    end
  end

endmodule
